// File: rtl/sched_pkg.sv
// sched_pkg: shared field offsets, class codes, FSM states and field decode for the dual-issue scheduler
package sched_pkg;

    localparam int RD_LSB  = 51;
    localparam int RS1_LSB = 46;
    localparam int RS2_LSB = 41;
    localparam int FU_LSB  = 39;
    localparam int FIELD_W = RD_LSB + 5 - FU_LSB;

    localparam logic [1:0] FU_ANY = 2'd0;
    localparam logic [1:0] FU_EU1 = 2'd1;

    typedef enum logic {ST_RUN = 1'b0, ST_FLUSH = 1'b1} state_t;

    typedef struct packed {
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [1:0] fu;
    } fields_t;

    // Takes the bundle slice [RD_LSB+4:FU_LSB]
    function automatic fields_t decode(input logic [FIELD_W-1:0] f);
        fields_t d;
        d.rd  = f[RD_LSB - FU_LSB +: 5];
        d.rs1 = f[RS1_LSB - FU_LSB +: 5];
        d.rs2 = f[RS2_LSB - FU_LSB +: 5];
        d.fu  = f[1:0];
        return d;
    endfunction

endpackage

// File: rtl/dual_issue_scheduler_if.sv
// dual_issue_scheduler_if: FIFO, issue-slot and writeback signals between the scheduler and its neighbours
interface dual_issue_scheduler_if #(parameter int INSTR_W = 64) ();

    logic [INSTR_W-1:0] fifo_instr1_i;
    logic [INSTR_W-1:0] fifo_instr2_i;
    logic               fifo_valid1_i;
    logic               fifo_valid2_i;
    logic [1:0]         deq_cnt_o;
    logic               fifo_flush_o;
    logic               fifo_stall_o;
    logic               iss0_valid_o;
    logic [INSTR_W-1:0] iss0_instr_o;
    logic               iss0_ready_i;
    logic               iss1_valid_o;
    logic [INSTR_W-1:0] iss1_instr_o;
    logic               iss1_ready_i;
    logic               wb0_valid_i;
    logic [4:0]         wb0_rd_i;
    logic               wb1_valid_i;
    logic [4:0]         wb1_rd_i;

    modport master (
        input  fifo_instr1_i, fifo_instr2_i, fifo_valid1_i, fifo_valid2_i,
        input  iss0_ready_i, iss1_ready_i,
        input  wb0_valid_i, wb0_rd_i, wb1_valid_i, wb1_rd_i,
        output deq_cnt_o, fifo_flush_o, fifo_stall_o,
        output iss0_valid_o, iss0_instr_o, iss1_valid_o, iss1_instr_o
    );

    modport slave (
        output fifo_instr1_i, fifo_instr2_i, fifo_valid1_i, fifo_valid2_i,
        output iss0_ready_i, iss1_ready_i,
        output wb0_valid_i, wb0_rd_i, wb1_valid_i, wb1_rd_i,
        input  deq_cnt_o, fifo_flush_o, fifo_stall_o,
        input  iss0_valid_o, iss0_instr_o, iss1_valid_o, iss1_instr_o
    );

endinterface

// File: rtl/sched_scoreboard.sv
// sched_scoreboard: per-register busy bits with two set lanes, two clear lanes, sync clear and six read ports
module sched_scoreboard #(
    parameter int NUM_REGS = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear,
    input  logic [1:0]      set_en,
    input  logic [1:0][4:0] set_rd,
    input  logic            clr0_en,
    input  logic [4:0]      clr0_rd,
    input  logic            clr1_en,
    input  logic [4:0]      clr1_rd,
    input  logic [5:0][4:0] q_rd,
    output logic [5:0]      q_busy
);

    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_d;
    logic [31:0]         view;

    assign view = 32'(busy);

    // Next busy state: a set beats a clear on the same register, x0 never becomes busy
    always_comb begin
        busy_d = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            busy_d[i] = (set_en[0] && int'(set_rd[0]) == i) || (set_en[1] && int'(set_rd[1]) == i) ||
                        (busy[i] && !((clr0_en && int'(clr0_rd) == i) || (clr1_en && int'(clr1_rd) == i)));
        end
    end

    // Busy bits, wiped wholesale on a pipeline flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy <= '0;
        else busy <= clear ? '0 : busy_d;
    end

    // Registered view only; writebacks in flight are not bypassed
    always_comb begin
        q_busy = '0;
        for (int k = 0; k < 6; k++) q_busy[k] = view[q_rd[k]];
    end

endmodule

// File: rtl/dual_issue_scheduler.sv
// dual_issue_scheduler: in-order dual issue from FIFO head pair to EU0/EU1 with flush sequencing; SCHED_PERF_CNT_EN adds perf counters
module dual_issue_scheduler
    import sched_pkg::*;
#(
    parameter int INSTR_W      = 64,
    parameter int NUM_REGS     = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    dual_issue_scheduler_if.master        bus,
    input  logic                          flush_i,
    output logic [31:0]                   perf_issued_o,
    output logic [31:0]                   perf_dual_o,
    output logic [31:0]                   perf_hazard_o
);

    localparam int CW = $clog2(FLUSH_CYCLES + 1);

    state_t             state;
    logic [CW-1:0]      cnt;
    logic               flush_q, stall_q;
    logic               v0, v1;
    logic [INSTR_W-1:0] i0, i1;
    fields_t            fa, fb;
    logic [5:0]         busy;
    logic               run, free0, free1, a_eu1, b_eu1, b_dep, iss_a, iss_b, load0, load1;
    logic [1:0]         deq;

    assign fa = decode(bus.fifo_instr1_i[RD_LSB+4:FU_LSB]);
    assign fb = decode(bus.fifo_instr2_i[RD_LSB+4:FU_LSB]);

    // Issue decision: A by its class, B only behind A into the other slot and free of A's destination
    always_comb begin
        run   = state == ST_RUN;
        free0 = !v0 || bus.iss0_ready_i;
        free1 = !v1 || bus.iss1_ready_i;
        a_eu1 = fa.fu == FU_EU1;
        b_eu1 = fb.fu == FU_EU1;
        b_dep = (fa.rd != 5'd0) && (fb.rs1 == fa.rd || fb.rs2 == fa.rd || fb.rd == fa.rd);
        iss_a = run && bus.fifo_valid1_i && !(|busy[2:0]) && (a_eu1 ? free1 : free0);
        iss_b = iss_a && bus.fifo_valid2_i && !(|busy[5:3]) && !b_dep && (a_eu1 ? (free0 && !b_eu1) : free1);
        load0 = a_eu1 ? iss_b : iss_a;
        load1 = a_eu1 ? iss_a : iss_b;
        deq   = {1'b0, iss_a} + {1'b0, iss_b};
    end

    assign bus.deq_cnt_o    = deq;
    assign bus.fifo_flush_o = flush_q;
    assign bus.fifo_stall_o = stall_q;
    assign bus.iss0_valid_o = v0;
    assign bus.iss0_instr_o = i0;
    assign bus.iss1_valid_o = v1;
    assign bus.iss1_instr_o = i1;

    // RUN/FLUSH sequencer; a flush request in either state (re)starts the count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_RUN;
            cnt     <= '0;
            flush_q <= 1'b0;
            stall_q <= 1'b0;
        end else if (flush_i) begin
            state   <= ST_FLUSH;
            cnt     <= '0;
            flush_q <= 1'b1;
            stall_q <= 1'b1;
        end else if (state == ST_FLUSH) begin
            flush_q <= 1'b0;
            if (cnt == CW'(FLUSH_CYCLES - 1)) begin
                state   <= ST_RUN;
                stall_q <= 1'b0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Issue slots: reload only when free so a stalled slot holds its bundle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v0 <= 1'b0;
            v1 <= 1'b0;
            i0 <= '0;
            i1 <= '0;
        end else if (flush_i) begin
            v0 <= 1'b0;
            v1 <= 1'b0;
        end else begin
            if (free0) begin
                v0 <= load0;
                if (load0) i0 <= a_eu1 ? bus.fifo_instr2_i : bus.fifo_instr1_i;
            end
            if (free1) begin
                v1 <= load1;
                if (load1) i1 <= a_eu1 ? bus.fifo_instr1_i : bus.fifo_instr2_i;
            end
        end
    end

    sched_scoreboard #(.NUM_REGS(NUM_REGS)) u_sb (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (flush_i),
        .set_en  ({iss_b, iss_a}),
        .set_rd  ({fb.rd, fa.rd}),
        .clr0_en (bus.wb0_valid_i && run),
        .clr0_rd (bus.wb0_rd_i),
        .clr1_en (bus.wb1_valid_i && run),
        .clr1_rd (bus.wb1_rd_i),
        .q_rd    ({fb.rd, fb.rs2, fb.rs1, fa.rd, fa.rs2, fa.rs1}),
        .q_busy  (busy)
    );

`ifdef SCHED_PERF_CNT_EN
    logic [31:0] perf_issued, perf_dual, perf_hazard;

    // Wrapping event counters, untouched by flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_issued <= '0;
            perf_dual   <= '0;
            perf_hazard <= '0;
        end else begin
            perf_issued <= perf_issued + 32'(deq);
            perf_dual   <= perf_dual + 32'(deq == 2'd2);
            perf_hazard <= perf_hazard + 32'(run && bus.fifo_valid1_i && !iss_a);
        end
    end

    assign perf_issued_o = perf_issued;
    assign perf_dual_o   = perf_dual;
    assign perf_hazard_o = perf_hazard;
`else
    assign perf_issued_o = '0;
    assign perf_dual_o   = '0;
    assign perf_hazard_o = '0;
`endif

endmodule

// File: tb/tb_dual_issue_scheduler.sv
// tb_dual_issue_scheduler: directed scenarios for the dual-issue scheduler
module tb_dual_issue_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        flush_i = 1'b0;
    logic [31:0] perf_issued_o, perf_dual_o, perf_hazard_o;
    int          passed = 0;
    int          total = 0;

    always #5 clk = ~clk;

    dual_issue_scheduler_if #(.INSTR_W(64)) bus ();

    dual_issue_scheduler #(.INSTR_W(64), .NUM_REGS(32), .FLUSH_CYCLES(2)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus),
        .flush_i       (flush_i),
        .perf_issued_o (perf_issued_o),
        .perf_dual_o   (perf_dual_o),
        .perf_hazard_o (perf_hazard_o)
    );

    function automatic logic [63:0] mk(input int rd, input int rs1, input int rs2, input int fu, input int id);
        return {8'h00, 5'(rd), 5'(rs1), 5'(rs2), 2'(fu), 39'(id)};
    endfunction

    task automatic idle();
        bus.fifo_instr1_i = '0;
        bus.fifo_instr2_i = '0;
        bus.fifo_valid1_i = 1'b0;
        bus.fifo_valid2_i = 1'b0;
        bus.iss0_ready_i  = 1'b1;
        bus.iss1_ready_i  = 1'b1;
        bus.wb0_valid_i   = 1'b0;
        bus.wb0_rd_i      = '0;
        bus.wb1_valid_i   = 1'b0;
        bus.wb1_rd_i      = '0;
        flush_i           = 1'b0;
    endtask

    task automatic reset_dut();
        idle();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drive(input logic [63:0] a, input logic va, input logic [63:0] b, input logic vb);
        bus.fifo_instr1_i = a;
        bus.fifo_valid1_i = va;
        bus.fifo_instr2_i = b;
        bus.fifo_valid2_i = vb;
    endtask

    task automatic test_reset();
        idle();
        #1 rst_n = 1'b0;
        @(negedge clk);
        total++;
        if ({bus.deq_cnt_o, bus.fifo_flush_o, bus.fifo_stall_o, bus.iss0_valid_o, bus.iss1_valid_o} !== 6'd0)
            $display("FAIL reset_ctrl got %b want 0", {bus.deq_cnt_o, bus.fifo_flush_o, bus.fifo_stall_o, bus.iss0_valid_o, bus.iss1_valid_o});
        else passed++;
        total++;
        if ({bus.iss0_instr_o, bus.iss1_instr_o} !== 128'd0)
            $display("FAIL reset_instr got %h %h want 0", bus.iss0_instr_o, bus.iss1_instr_o);
        else passed++;
        total++;
        if ({perf_issued_o, perf_dual_o, perf_hazard_o} !== 96'd0)
            $display("FAIL reset_perf got %0d %0d %0d want 0", perf_issued_o, perf_dual_o, perf_hazard_o);
        else passed++;
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if ({bus.fifo_flush_o, bus.fifo_stall_o, bus.iss0_valid_o, bus.iss1_valid_o} !== 4'd0)
            $display("FAIL reset_release got %b want 0", {bus.fifo_flush_o, bus.fifo_stall_o, bus.iss0_valid_o, bus.iss1_valid_o});
        else passed++;
    endtask

    task automatic test_pair();
        logic [63:0] a, b;
        reset_dut();
        a = mk(1, 2, 3, 0, 11);
        b = mk(4, 5, 6, 0, 12);
        drive(a, 1'b1, b, 1'b1);
        #1;
        total++;
        if (bus.deq_cnt_o !== 2'd2) $display("FAIL pair_deq got %0d want 2", bus.deq_cnt_o); else passed++;
        @(negedge clk);
        total++;
        if ({bus.iss0_valid_o, bus.iss0_instr_o} !== {1'b1, a}) $display("FAIL pair_iss0 got %b %h want 1 %h", bus.iss0_valid_o, bus.iss0_instr_o, a); else passed++;
        total++;
        if ({bus.iss1_valid_o, bus.iss1_instr_o} !== {1'b1, b}) $display("FAIL pair_iss1 got %b %h want 1 %h", bus.iss1_valid_o, bus.iss1_instr_o, b); else passed++;
`ifdef SCHED_PERF_CNT_EN
        total++;
        if ({perf_issued_o, perf_dual_o} !== {32'd2, 32'd1}) $display("FAIL pair_perf got %0d %0d want 2 1", perf_issued_o, perf_dual_o); else passed++;
`else
        total++;
        if ({perf_issued_o, perf_dual_o} !== 64'd0) $display("FAIL pair_perf got %0d %0d want 0 0", perf_issued_o, perf_dual_o); else passed++;
`endif
        drive(mk(9, 1, 0, 0, 13), 1'b1, '0, 1'b0);
        #1;
        total++;
        if (bus.deq_cnt_o !== 2'd0) $display("FAIL pair_busy_x1 got %0d want 0", bus.deq_cnt_o); else passed++;
        @(negedge clk);
        drive(mk(9, 4, 0, 0, 14), 1'b1, '0, 1'b0);
        #1;
        total++;
        if (bus.deq_cnt_o !== 2'd0) $display("FAIL pair_busy_x4 got %0d want 0", bus.deq_cnt_o); else passed++;
        total++;
        if ({bus.iss0_valid_o, bus.iss1_valid_o} !== 2'b00) $display("FAIL pair_drain got %b want 00", {bus.iss0_valid_o, bus.iss1_valid_o}); else passed++;
    endtask

    task automatic test_intra_raw();
        logic [63:0] a, b;
        reset_dut();
        a = mk(1, 2, 3, 0, 21);
        b = mk(5, 1, 0, 0, 22);
        drive(a, 1'b1, b, 1'b1);
        #1;
        total++;
        if (bus.deq_cnt_o !== 2'd1) $display("FAIL raw_deq got %0d want 1", bus.deq_cnt_o); else passed++;
        @(negedge clk);
        drive(b, 1'b1, '0, 1'b0);
        bus.wb0_valid_i = 1'b1;
        bus.wb0_rd_i = 5'd1;
        total++;
        if ({bus.iss0_valid_o, bus.iss0_instr_o, bus.iss1_valid_o} !== {1'b1, a, 1'b0}) $display("FAIL raw_iss got %b %h %b want 1 %h 0", bus.iss0_valid_o, bus.iss0_instr_o, bus.iss1_valid_o, a); else passed++;
        #1;
        total++;
        if (bus.deq_cnt_o !== 2'd0) $display("FAIL raw_no_bypass got %0d want 0", bus.deq_cnt_o); else passed++;
        @(negedge clk);
        bus.wb0_valid_i = 1'b0;
        #1;
        total++;
        if (bus.deq_cnt_o !== 2'd1) $display("FAIL raw_b_issue got %0d want 1", bus.deq_cnt_o); else passed++;
        @(negedge clk);
        idle();
        total++;
        if ({bus.iss0_valid_o, bus.iss0_instr_o} !== {1'b1, b}) $display("FAIL raw_b_iss0 got %b %h want 1 %h", bus.iss0_valid_o, bus.iss0_instr_o, b); else passed++;
    endtask

    task automatic test_class_conflict();
        logic [63:0] a, b;
        reset_dut();
        a = mk(1, 2, 3, 1, 31);
        b = mk(4, 5, 6, 1, 32);
        bus.iss1_ready_i = 1'b0;
        drive(a, 1'b1, b, 1'b1);
        #1;
        total++;
        if (bus.deq_cnt_o !== 2'd1) $display("FAIL class_deq got %0d want 1", bus.deq_cnt_o); else passed++;
        @(negedge clk);
        drive(b, 1'b1, '0, 1'b0);
        total++;
        if ({bus.iss1_valid_o, bus.iss1_instr_o, bus.iss0_valid_o} !== {1'b1, a, 1'b0}) $display("FAIL class_a_eu1 got %b %h %b want 1 %h 0", bus.iss1_valid_o, bus.iss1_instr_o, bus.iss0_valid_o, a); else passed++;
        #1;
        total++;
        if (bus.deq_cnt_o !== 2'd0) $display("FAIL class_b_wait got %0d want 0", bus.deq_cnt_o); else passed++;
        @(negedge clk);
        bus.iss1_ready_i = 1'b1;
        #1;
        total++;
        if (bus.deq_cnt_o !== 2'd1) $display("FAIL class_b_go got %0d want 1", bus.deq_cnt_o); else passed++;
        @(negedge clk);
        idle();
        total++;
        if ({bus.iss1_valid_o, bus.iss1_instr_o} !== {1'b1, b}) $display("FAIL class_b_eu1 got %b %h want 1 %h", bus.iss1_valid_o, bus.iss1_instr_o, b); else passed++;
    endtask

    task automatic test_cross_route();
        logic [63:0] a, b;
        reset_dut();
        a = mk(1, 2, 3, 1, 41);
        b = mk(4, 5, 6, 0, 42);
        drive(a, 1'b1, b, 1'b1);
        #1;
        total++;
        if (bus.deq_cnt_o !== 2'd2) $display("FAIL cross_deq got %0d want 2", bus.deq_cnt_o); else passed++;
        @(negedge clk);
        idle();
        total++;
        if ({bus.iss0_instr_o, bus.iss1_instr_o} !== {b, a}) $display("FAIL cross_route got %h %h want %h %h", bus.iss0_instr_o, bus.iss1_instr_o, b, a); else passed++;
        reset_dut();
        a = mk(1, 2, 3, 2, 43);
        b = mk(4, 5, 6, 1, 44);
        drive(a, 1'b1, b, 1'b1);
        #1;
        total++;
        if (bus.deq_cnt_o !== 2'd2) $display("FAIL reserved_deq got %0d want 2", bus.deq_cnt_o); else passed++;
        @(negedge clk);
        idle();
        total++;
        if ({bus.iss0_instr_o, bus.iss1_instr_o} !== {a, b}) $display("FAIL reserved_route got %h %h want %h %h", bus.iss0_instr_o, bus.iss1_instr_o, a, b); else passed++;
    endtask

    task automatic test_backpressure();
        logic [63:0] a0, a1;
        reset_dut();
        a0 = mk(1, 2, 3, 0, 51);
        a1 = mk(4, 5, 6, 0, 52);
        bus.iss0_ready_i = 1'b0;
        drive(a0, 1'b1, '0, 1'b0);
        #1;
        total++;
        if (bus.deq_cnt_o !== 2'd1) $display("FAIL bp_first got %0d want 1", bus.deq_cnt_o); else passed++;
        @(negedge clk);
        drive(a1, 1'b1, '0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            #1;
            total++;
            if (bus.deq_cnt_o !== 2'd0) $display("FAIL bp_block[%0d] got %0d want 0", c, bus.deq_cnt_o); else passed++;
            total++;
            if ({bus.iss0_valid_o, bus.iss0_instr_o} !== {1'b1, a0}) $display("FAIL bp_hold[%0d] got %b %h want 1 %h", c, bus.iss0_valid_o, bus.iss0_instr_o, a0); else passed++;
            @(negedge clk);
        end
        bus.iss0_ready_i = 1'b1;
        #1;
        total++;
        if (bus.deq_cnt_o !== 2'd1) $display("FAIL bp_release got %0d want 1", bus.deq_cnt_o); else passed++;
        @(negedge clk);
        idle();
        total++;
        if ({bus.iss0_valid_o, bus.iss0_instr_o} !== {1'b1, a1}) $display("FAIL bp_next got %b %h want 1 %h", bus.iss0_valid_o, bus.iss0_instr_o, a1); else passed++;
    endtask

    task automatic test_flush();
        reset_dut();
        drive(mk(1, 2, 3, 0, 61), 1'b1, mk(4, 5, 6, 0, 62), 1'b1);
        @(negedge clk);
        drive('0, 1'b0, '0, 1'b0);
        flush_i = 1'b1;
        total++;
        if ({bus.iss0_valid_o, bus.iss1_valid_o} !== 2'b11) $display("FAIL flush_pre got %b want 11", {bus.iss0_valid_o, bus.iss1_valid_o}); else passed++;
        @(negedge clk);
        flush_i = 1'b0;
        drive(mk(8, 1, 4, 0, 63), 1'b1, '0, 1'b0);
        total++;
        if ({bus.fifo_flush_o, bus.fifo_stall_o, bus.iss0_valid_o, bus.iss1_valid_o} !== 4'b1100) $display("FAIL flush_c1 got %b want 1100", {bus.fifo_flush_o, bus.fifo_stall_o, bus.iss0_valid_o, bus.iss1_valid_o}); else passed++;
        #1;
        total++;
        if (bus.deq_cnt_o !== 2'd0) $display("FAIL flush_c1_deq got %0d want 0", bus.deq_cnt_o); else passed++;
        @(negedge clk);
        total++;
        if ({bus.fifo_flush_o, bus.fifo_stall_o} !== 2'b01) $display("FAIL flush_c2 got %b want 01", {bus.fifo_flush_o, bus.fifo_stall_o}); else passed++;
        #1;
        total++;
        if (bus.deq_cnt_o !== 2'd0) $display("FAIL flush_c2_deq got %0d want 0", bus.deq_cnt_o); else passed++;
        @(negedge clk);
        total++;
        if ({bus.fifo_flush_o, bus.fifo_stall_o} !== 2'b00) $display("FAIL flush_exit got %b want 00", {bus.fifo_flush_o, bus.fifo_stall_o}); else passed++;
        #1;
        total++;
        if (bus.deq_cnt_o !== 2'd1) $display("FAIL flush_sb_clear got %0d want 1", bus.deq_cnt_o); else passed++;
        @(negedge clk);
        idle();
    endtask

    task automatic test_flush_restart();
        reset_dut();
        flush_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
        flush_i = 1'b0;
        total++;
        if ({bus.fifo_flush_o, bus.fifo_stall_o} !== 2'b11) $display("FAIL restart_flush got %b want 11", {bus.fifo_flush_o, bus.fifo_stall_o}); else passed++;
        @(negedge clk);
        total++;
        if ({bus.fifo_flush_o, bus.fifo_stall_o} !== 2'b01) $display("FAIL restart_c2 got %b want 01", {bus.fifo_flush_o, bus.fifo_stall_o}); else passed++;
        @(negedge clk);
        total++;
        if ({bus.fifo_flush_o, bus.fifo_stall_o} !== 2'b00) $display("FAIL restart_exit got %b want 00", {bus.fifo_flush_o, bus.fifo_stall_o}); else passed++;
    endtask

    task automatic test_x0();
        reset_dut();
        drive(mk(0, 2, 3, 0, 71), 1'b1, mk(4, 0, 0, 0, 72), 1'b1);
        #1;
        total++;
        if (bus.deq_cnt_o !== 2'd2) $display("FAIL x0_pair got %0d want 2", bus.deq_cnt_o); else passed++;
        @(negedge clk);
        drive(mk(5, 0, 0, 0, 73), 1'b1, '0, 1'b0);
        #1;
        total++;
        if (bus.deq_cnt_o !== 2'd1) $display("FAIL x0_never_busy got %0d want 1", bus.deq_cnt_o); else passed++;
        @(negedge clk);
        idle();
    endtask

    task automatic test_set_wins_and_async_reset();
        logic [63:0] c;
        reset_dut();
        c = mk(9, 7, 0, 0, 82);
        drive(mk(7, 2, 3, 0, 81), 1'b1, '0, 1'b0);
        bus.wb0_valid_i = 1'b1;
        bus.wb0_rd_i = 5'd7;
        #1;
        total++;
        if (bus.deq_cnt_o !== 2'd1) $display("FAIL setwin_issue got %0d want 1", bus.deq_cnt_o); else passed++;
        @(negedge clk);
        bus.wb0_valid_i = 1'b0;
        drive(c, 1'b1, '0, 1'b0);
        #1;
        total++;
        if (bus.deq_cnt_o !== 2'd0) $display("FAIL setwin_x7_busy got %0d want 0", bus.deq_cnt_o); else passed++;
        @(negedge clk);
        bus.wb0_valid_i = 1'b1;
        bus.wb0_rd_i = 5'd7;
        bus.wb1_valid_i = 1'b1;
        bus.wb1_rd_i = 5'd7;
        #1;
        total++;
        if (bus.deq_cnt_o !== 2'd0) $display("FAIL dualwb_pending got %0d want 0", bus.deq_cnt_o); else passed++;
        @(negedge clk);
        bus.wb0_valid_i = 1'b0;
        bus.wb1_valid_i = 1'b0;
        #1;
        total++;
        if (bus.deq_cnt_o !== 2'd1) $display("FAIL dualwb_cleared got %0d want 1", bus.deq_cnt_o); else passed++;
        @(negedge clk);
        drive('0, 1'b0, '0, 1'b0);
        total++;
        if ({bus.iss0_valid_o, bus.iss0_instr_o} !== {1'b1, c}) $display("FAIL async_pre got %b %h want 1 %h", bus.iss0_valid_o, bus.iss0_instr_o, c); else passed++;
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({bus.iss0_valid_o, bus.iss0_instr_o} !== 65'd0) $display("FAIL async_reset got %b %h want 0", bus.iss0_valid_o, bus.iss0_instr_o); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_pair();
        test_intra_raw();
        test_class_conflict();
        test_cross_route();
        test_backpressure();
        test_flush();
        test_flush_restart();
        test_x0();
        test_set_wins_and_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/dual_issue_scheduler.md
Name: dual_issue_scheduler

Overview:
Dual-issue in-order scheduler that sits between the decode instruction FIFO and two execution units (EU0 general ALU, EU1 ALU plus MUL/branch).
- Each cycle it inspects the two FIFO head entries, checks hazards against a register scoreboard, and routes 0, 1 or 2 instructions into registered issue slots.
- It returns the dequeue count to the FIFO and sequences pipeline flushes, including the FIFO flush and scoreboard clear.

Parameters:
INSTR_W, 64, instruction bundle width
NUM_REGS, 32, architectural registers tracked by the scoreboard (x0 never busy)
FLUSH_CYCLES, 2, cycles spent in FLUSH state (minimum 1)

Ports:
clk  in  1  clock
rst_n  in  1  reset; asynchronous, active-low
fifo_instr1_i  in  INSTR_W  FIFO head entry (oldest)
fifo_instr2_i  in  INSTR_W  FIFO head+1 entry
fifo_valid1_i  in  1  head entry valid
fifo_valid2_i  in  1  head+1 entry valid
deq_cnt_o  out  2  entries consumed this cycle (0/1/2), combinational
fifo_flush_o  out  1  flush request to FIFO
fifo_stall_o  out  1  blocks FIFO enqueue while flushing
flush_i  in  1  redirect/flush request from branch resolution
iss0_valid_o  out  1  EU0 issue valid
iss0_instr_o  out  INSTR_W  EU0 instruction
iss0_ready_i  in  1  EU0 accepts
iss1_valid_o  out  1  EU1 issue valid
iss1_instr_o  out  INSTR_W  EU1 instruction
iss1_ready_i  in  1  EU1 accepts
wb0_valid_i  in  1  writeback port 0 valid
wb0_rd_i  in  5  writeback port 0 destination
wb1_valid_i  in  1  writeback port 1 valid
wb1_rd_i  in  5  writeback port 1 destination
perf_issued_o  out  32  total instructions issued (optional feature)
perf_dual_o  out  32  dual-issue cycles (optional feature)
perf_hazard_o  out  32  cycles where slot A was valid but blocked (optional feature)

Behaviour:
- Instruction fields: rd [55:51], rs1 [50:46], rs2 [45:41], fu_class [40:39]. fu_class 0 runs on either EU; 1 runs on EU1 only; 2 and 3 are reserved and treated as 0.
- Reset: every output is 0, all scoreboard bits clear, FSM in RUN, perf counters 0.
- FSM has two states.
  - RUN: normal issue. flush_i=1 moves to FLUSH.
  - FLUSH: lasts FLUSH_CYCLES cycles, counted by an internal counter.
    - fifo_flush_o=1 on the first cycle only; fifo_stall_o=1 for the whole state.
    - deq_cnt_o=0, no issue, both issue valids forced to 0 on entry.
    - Scoreboard cleared on entry; writebacks are ignored while in FLUSH.
    - Returns to RUN after the count. flush_i during FLUSH restarts the count.
- Slot free: slotN_free = !issN_valid_o | issN_ready_i.
- Hazard for an entry: any of rs1, rs2, rd busy in the scoreboard (RAW plus WAW). The scoreboard is the registered view; there is no writeback bypass.
- Entry A (instr1) issues when all hold: RUN, fifo_valid1_i, no hazard, and its target slot free. Target is EU0 for class 0, EU1 for class 1.
- Entry B (instr2) issues only if A issues this cycle (strict in-order). It also needs:
  - fifo_valid2_i and no scoreboard hazard.
  - B.rs1, B.rs2, B.rd ≠ A.rd whenever A.rd ≠ 0.
  - The remaining EU slot free. If A took EU0, B takes EU1 (any class). If A took EU1, B takes EU0 and B must be class 0.
- deq_cnt_o = issA + issB, combinational in the same cycle.
- Issue registers load in the cycle after the decision becomes visible (1-cycle latency FIFO→EU). valid/instr are held stable while valid=1 and ready=0.
- Scoreboard: issue sets bit rd (rd ≠ 0). wb0/wb1 clear their bits. Same-cycle set and clear on one register: set wins. Two writebacks to the same rd clear once.

Optional Feature:
SCHED_PERF_CNT_EN
- Defined: three 32-bit wrapping counters drive the perf_* ports.
  - perf_issued_o adds deq_cnt_o.
  - perf_dual_o increments when deq_cnt_o=2.
  - perf_hazard_o increments when RUN, fifo_valid1_i and A is not issued.
  - All reset to 0 and are not cleared by flush.
- Undefined: perf_* ports tied to 0 and no counter flops.

Decomposition:
- Package sched_pkg holds:
  - field offset constants (RD_LSB, RS1_LSB, RS2_LSB, FU_LSB)
  - fu_class constants (FU_ANY=0, FU_EU1=1)
  - FSM state encodings (ST_RUN, ST_FLUSH)
- One natural sub-module, sched_scoreboard: NUM_REGS busy bits, a set port, two clear ports, a sync clear, and three combinational read ports per entry.

Test Plan:
1. Independent pair: A=add x1,x2,x3 (class 0), B=add x4,x5,x6; both slots free → deq_cnt_o=2; next cycle iss0 holds A, iss1 holds B; busy x1 and x4 set.
2. Intra-pair RAW: A writes x1, B reads x1 → deq_cnt_o=1, A to EU0. Next cycle B issues alone after wb0_rd_i=1, with one extra cycle since there is no bypass.
3. Class conflict: A class 1, B class 1 → only A issues, to EU1. Then B issues the following cycle once iss1_ready_i=1.
4. Backpressure: iss0_ready_i=0 with iss0_valid_o=1 for 3 cycles → iss0_instr_o stable, class-0 A blocked, deq_cnt_o=0 throughout.
5. Flush mid-stream: busy x1, valid slots, then flush_i pulse → fifo_flush_o=1 for 1 cycle, fifo_stall_o=1 for 2 cycles, issue valids 0, scoreboard clear; an instruction reading x1 then issues immediately on return to RUN.
6. Same-cycle issue and writeback to x7 → x7 remains busy. Asserting rst_n=0 mid-operation clears all outputs asynchronously.
